// File: rtl/load_store_unit_pkg.sv
// Shared constants for the RV32I data-memory access stage: funct3 length codes, FSM states,
// and alignment helpers.
package load_store_unit_pkg;

   localparam int MEM_WORD_BYTES = 4;
   localparam int MEM_DATA_WIDTH = 32;

   localparam logic [2:0] MEM_LEN_B  = 3'b000;
   localparam logic [2:0] MEM_LEN_H  = 3'b001;
   localparam logic [2:0] MEM_LEN_W  = 3'b010;
   localparam logic [2:0] MEM_LEN_BU = 3'b100;
   localparam logic [2:0] MEM_LEN_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACCESS0 = 2'd1,
      ST_ACCESS1 = 2'd2,
      ST_DONE    = 2'd3
   } lsu_state_e;

   function automatic logic mem_is_aligned(input logic [2:0] len, input logic [1:0] off);
      case (len[1:0])
         2'b00:   return 1'b1;
         2'b01:   return ~off[0];
         default: return (off == 2'b00);
      endcase
   endfunction

   function automatic logic mem_crosses_word(input logic [2:0] len, input logic [1:0] off);
      case (len[1:0])
         2'b00:   return 1'b0;
         2'b01:   return (off == 2'b11);
         default: return (off != 2'b00);
      endcase
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-bus request/ready interface between the load/store unit (master) and memory (slave).
interface load_store_unit_if #(parameter int ADDR_WIDTH = 32);

   logic                  bus_req;
   logic                  bus_we;
   logic [ADDR_WIDTH-1:0] bus_addr;
   logic [31:0]           bus_wdata;
   logic [3:0]            bus_wstrb;
   logic                  bus_ready;
   logic [31:0]           bus_rdata;

   modport master (
      output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
      input  bus_ready, bus_rdata
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
      output bus_ready, bus_rdata
   );

endinterface

// File: rtl/load_store_unit_align.sv
// lsu_align: lane steering for stores and byte extraction/extension for loads, over a
// two-word window so that word-crossing accesses use the same path.
module lsu_align
   import load_store_unit_pkg::*;
(
   input  logic [1:0]  i_offset,
   input  logic [2:0]  i_len,
   input  logic [31:0] i_store_data,
   input  logic [31:0] i_rdata_lo,
   input  logic [31:0] i_rdata_hi,
   output logic [63:0] o_wdata,
   output logic [7:0]  o_wstrb,
   output logic [31:0] o_load_value
);

   logic [31:0] w_sdata;
   logic [3:0]  w_smask;
   logic [63:0] w_rshift;

   always_comb begin
      w_sdata = i_store_data;
      w_smask = 4'b1111;
      case (i_len[1:0])
         2'b00: begin
            w_sdata = {24'd0, i_store_data[7:0]};
            w_smask = 4'b0001;
         end
         2'b01: begin
            w_sdata = {16'd0, i_store_data[15:0]};
            w_smask = 4'b0011;
         end
         default: ;
      endcase

      o_wdata  = {32'd0, w_sdata} << {i_offset, 3'b000};
      o_wstrb  = {4'd0, w_smask} << i_offset;
      w_rshift = {i_rdata_hi, i_rdata_lo} >> {i_offset, 3'b000};

      case (i_len)
         MEM_LEN_B:  o_load_value = {{24{w_rshift[7]}}, w_rshift[7:0]};
         MEM_LEN_BU: o_load_value = {24'd0, w_rshift[7:0]};
         MEM_LEN_H:  o_load_value = {{16{w_rshift[15]}}, w_rshift[15:0]};
         MEM_LEN_HU: o_load_value = {16'd0, w_rshift[15:0]};
         default:    o_load_value = w_rshift[31:0];
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: request/ready bus FSM that stalls the core until the access completes.
// LSU_MISALIGNED_SPLIT_EN splits word-crossing accesses into two beats instead of faulting them.
//
// state      | meaning
// ST_IDLE    | waiting for start with mem_read/mem_write
// ST_ACCESS0 | bus beat on the (lower) word, held until bus_ready
// ST_ACCESS1 | second beat on word+4 for a split access
// ST_DONE    | one-cycle done pulse, then back to idle
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic                  mem_read,
   input  logic                  mem_write,
   input  logic [2:0]            mem_op_length,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [31:0]           store_data,
   output logic                  busy,
   output logic                  done,
   output logic [31:0]           load_data,
   output logic                  misaligned,
   load_store_unit_if.master     bus
);

   lsu_state_e            r_state, w_next;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [31:0]           r_sdata;
   logic [2:0]            r_len;
   logic                  r_we;
   logic                  r_split;
   logic                  r_fault;
   logic [31:0]           r_rdata0;
   logic [31:0]           r_load_data;

   logic                  w_accept;
   logic                  w_split_in;
   logic                  w_fault_in;
   logic                  w_load_capture;
   logic [ADDR_WIDTH-1:0] w_word_addr;
   logic [63:0]           w_wdata64;
   logic [7:0]            w_wstrb8;
   logic [31:0]           w_rdata_lo;
   logic [31:0]           w_load_value;

   assign w_accept = (r_state == ST_IDLE) & start & (mem_read | mem_write);

`ifdef LSU_MISALIGNED_SPLIT_EN
   assign w_split_in = mem_crosses_word(mem_op_length, address[1:0]);
   assign w_fault_in = 1'b0;
`else
   assign w_split_in = 1'b0;
   assign w_fault_in = ~mem_is_aligned(mem_op_length, address[1:0]);
`endif

   assign w_word_addr = {r_addr[ADDR_WIDTH-1:2], 2'b00};
   // Second beat of a split load merges the held lower word with the live upper word.
   assign w_rdata_lo  = (r_state == ST_ACCESS1) ? r_rdata0 : bus.bus_rdata;

   lsu_align u_align (
      .i_offset     (r_addr[1:0]),
      .i_len        (r_len),
      .i_store_data (r_sdata),
      .i_rdata_lo   (w_rdata_lo),
      .i_rdata_hi   (bus.bus_rdata),
      .o_wdata      (w_wdata64),
      .o_wstrb      (w_wstrb8),
      .o_load_value (w_load_value)
   );

   always_comb begin
      w_next        = r_state;
      done          = 1'b0;
      bus.bus_req   = 1'b0;
      bus.bus_we    = 1'b0;
      bus.bus_addr  = '0;
      bus.bus_wdata = '0;
      bus.bus_wstrb = '0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) w_next = w_fault_in ? ST_DONE : ST_ACCESS0;
         end
         ST_ACCESS0: begin
            bus.bus_req   = 1'b1;
            bus.bus_we    = r_we;
            bus.bus_addr  = w_word_addr;
            bus.bus_wdata = r_we ? w_wdata64[31:0] : 32'd0;
            bus.bus_wstrb = r_we ? w_wstrb8[3:0] : 4'd0;
            if (bus.bus_ready) w_next = r_split ? ST_ACCESS1 : ST_DONE;
         end
         ST_ACCESS1: begin
            bus.bus_req   = 1'b1;
            bus.bus_we    = r_we;
            bus.bus_addr  = w_word_addr + ADDR_WIDTH'(MEM_WORD_BYTES);
            bus.bus_wdata = r_we ? w_wdata64[63:32] : 32'd0;
            bus.bus_wstrb = r_we ? w_wstrb8[7:4] : 4'd0;
            if (bus.bus_ready) w_next = ST_DONE;
         end
         ST_DONE: begin
            done   = 1'b1;
            w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   assign w_load_capture = ~r_we & bus.bus_ready &
                           (((r_state == ST_ACCESS0) & ~r_split) | (r_state == ST_ACCESS1));

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_addr      <= '0;
         r_sdata     <= '0;
         r_len       <= '0;
         r_we        <= 1'b0;
         r_split     <= 1'b0;
         r_fault     <= 1'b0;
         r_rdata0    <= '0;
         r_load_data <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_addr  <= address;
            r_sdata <= store_data;
            r_len   <= mem_op_length;
            r_we    <= ~mem_read;
            r_split <= w_split_in;
            r_fault <= w_fault_in;
         end
         if ((r_state == ST_ACCESS0) && bus.bus_ready) r_rdata0 <= bus.bus_rdata;
         if (w_load_capture) r_load_data <= w_load_value;
      end
   end

   assign load_data  = r_load_data;
   assign misaligned = (r_state == ST_DONE) & r_fault;
   assign busy       = (r_state != ST_IDLE) | (start & (mem_read | mem_write));

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: expected bus beats and results are queued per access and
// checked against the DUT as beats and done pulses appear.
module tb_load_store_unit;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      int          waits;
      logic [31:0] rdata;
   } beat_t;

   typedef struct {
      logic [31:0] ld;
      logic        mis;
      int          lat;
   } res_t;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        start;
   logic        mem_read;
   logic        mem_write;
   logic [2:0]  mem_op_length;
   logic [31:0] address;
   logic [31:0] store_data;
   logic        busy;
   logic        done;
   logic [31:0] load_data;
   logic        misaligned;

   int checks = 0;
   int errors = 0;
   logic [31:0] last_ld = 32'd0;

   beat_t beats[$];
   res_t  results[$];

   load_store_unit_if #(.ADDR_WIDTH(32)) bus_if ();

   load_store_unit #(.ADDR_WIDTH(32)) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .start         (start),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .mem_op_length (mem_op_length),
      .address       (address),
      .store_data    (store_data),
      .busy          (busy),
      .done          (done),
      .load_data     (load_data),
      .misaligned    (misaligned),
      .bus           (bus_if.master)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic void push_beat(input logic [31:0] a, input logic we, input logic [31:0] wd,
                                     input logic [3:0] st, input int w, input logic [31:0] rd);
      beat_t b;
      b.addr = a; b.we = we; b.wdata = wd; b.wstrb = st; b.waits = w; b.rdata = rd;
      beats.push_back(b);
   endfunction

   function automatic void push_res(input logic [31:0] ld, input logic mis, input int lat);
      res_t r;
      r.ld = ld; r.mis = mis; r.lat = lat;
      results.push_back(r);
      last_ld = ld;
   endfunction

   task automatic run_access(input logic rd, input logic wr, input logic [2:0] len,
                             input logic [31:0] addr, input logic [31:0] sdata,
                             input int hold_start, input logic [31:0] hold_addr);
      int   cyc;
      int   wcnt;
      logic got_done;
      res_t r;
      @(negedge clock);
      start = 1'b1; mem_read = rd; mem_write = wr; mem_op_length = len;
      address = addr; store_data = sdata; bus_if.bus_ready = 1'b0;
      #1 check("busy_start", {31'd0, busy}, 32'd1);
      cyc = 0; wcnt = 0; got_done = 1'b0;
      while (!got_done && cyc < 40) begin
         @(negedge clock);
         cyc++;
         if (bus_if.bus_req) begin
            if (beats.size() == 0) begin
               check("extra_req", {31'd0, bus_if.bus_req}, 32'd0);
               bus_if.bus_ready = 1'b0;
            end else begin
               check("bus_addr", bus_if.bus_addr, beats[0].addr);
               check("bus_we", {31'd0, bus_if.bus_we}, {31'd0, beats[0].we});
               check("bus_wdata", bus_if.bus_wdata, beats[0].wdata);
               check("bus_wstrb", {28'd0, bus_if.bus_wstrb}, {28'd0, beats[0].wstrb});
               if (wcnt == beats[0].waits) begin
                  bus_if.bus_ready = 1'b1;
                  bus_if.bus_rdata = beats[0].rdata;
                  void'(beats.pop_front());
                  wcnt = 0;
               end else begin
                  bus_if.bus_ready = 1'b0;
                  bus_if.bus_rdata = 32'h0BAD0BAD;
                  wcnt++;
               end
            end
         end else begin
            bus_if.bus_ready = 1'b0;
         end
         if (done) begin
            got_done = 1'b1;
            r = results.pop_front();
            check("latency", 32'(cyc), 32'(r.lat));
            check("load_data", load_data, r.ld);
            check("misaligned", {31'd0, misaligned}, {31'd0, r.mis});
            check("beats_left", 32'(beats.size()), 32'd0);
         end
         if (cyc > hold_start) begin
            start = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
         end else begin
            address = hold_addr; mem_read = 1'b1; mem_write = 1'b0;
         end
      end
      check("done_seen", {31'd0, got_done}, 32'd1);
      beats.delete();
      @(negedge clock);
      check("done_pulse", {31'd0, done}, 32'd0);
      check("busy_idle", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      reset_n = 1'b0; start = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
      mem_op_length = 3'b000; address = 32'd0; store_data = 32'd0;
      bus_if.bus_ready = 1'b0; bus_if.bus_rdata = 32'd0;
      #22;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_load_data", load_data, 32'd0);
      check("rst_misaligned", {31'd0, misaligned}, 32'd0);
      check("rst_bus_req", {31'd0, bus_if.bus_req}, 32'd0);
      check("rst_bus_we", {31'd0, bus_if.bus_we}, 32'd0);
      check("rst_bus_addr", bus_if.bus_addr, 32'd0);
      check("rst_bus_wdata", bus_if.bus_wdata, 32'd0);
      check("rst_bus_wstrb", {28'd0, bus_if.bus_wstrb}, 32'd0);
      @(negedge clock);
      reset_n = 1'b1;

      // SW aligned, zero wait
      push_beat(32'h100, 1'b1, 32'hDEADBEEF, 4'b1111, 0, 32'd0);
      push_res(last_ld, 1'b0, 2);
      run_access(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 32'd0);

      // LB / LBU from byte lane 3
      push_beat(32'h100, 1'b0, 32'd0, 4'b0000, 0, 32'h80112233);
      push_res(32'hFFFFFF80, 1'b0, 2);
      run_access(1'b1, 1'b0, 3'b000, 32'h103, 32'd0, 0, 32'd0);
      push_beat(32'h100, 1'b0, 32'd0, 4'b0000, 0, 32'h80112233);
      push_res(32'h00000080, 1'b0, 2);
      run_access(1'b1, 1'b0, 3'b100, 32'h103, 32'd0, 0, 32'd0);

      // SH upper half, 3 wait cycles, start held high (must be ignored) during the wait
      push_beat(32'h100, 1'b1, 32'hABCD0000, 4'b1100, 3, 32'd0);
      push_res(last_ld, 1'b0, 5);
      run_access(1'b0, 1'b1, 3'b001, 32'h102, 32'h0000ABCD, 2, 32'h300);

      // LH / LHU from upper half
      push_beat(32'h100, 1'b0, 32'd0, 4'b0000, 0, 32'h80011234);
      push_res(32'hFFFF8001, 1'b0, 2);
      run_access(1'b1, 1'b0, 3'b001, 32'h102, 32'd0, 0, 32'd0);
      push_beat(32'h100, 1'b0, 32'd0, 4'b0000, 0, 32'h80011234);
      push_res(32'h00008001, 1'b0, 2);
      run_access(1'b1, 1'b0, 3'b101, 32'h102, 32'd0, 0, 32'd0);

      // SB with junk upper store bits
      push_beat(32'h100, 1'b1, 32'h0000A500, 4'b0010, 0, 32'd0);
      push_res(last_ld, 1'b0, 2);
      run_access(1'b0, 1'b1, 3'b000, 32'h101, 32'h123456A5, 0, 32'd0);

      // LW aligned, one wait
      push_beat(32'h100, 1'b0, 32'd0, 4'b0000, 1, 32'h12345678);
      push_res(32'h12345678, 1'b0, 3);
      run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 0, 32'd0);

`ifdef LSU_MISALIGNED_SPLIT_EN
      push_beat(32'h100, 1'b0, 32'd0, 4'b0000, 0, 32'h44332211);
      push_beat(32'h104, 1'b0, 32'd0, 4'b0000, 0, 32'h88776655);
      push_res(32'h55443322, 1'b0, 3);
      run_access(1'b1, 1'b0, 3'b010, 32'h101, 32'd0, 0, 32'd0);
      push_beat(32'h100, 1'b1, 32'h00ABCD00, 4'b0110, 0, 32'd0);
      push_res(last_ld, 1'b0, 2);
      run_access(1'b0, 1'b1, 3'b001, 32'h101, 32'h0000ABCD, 0, 32'd0);
      push_beat(32'h100, 1'b1, 32'hDD000000, 4'b1000, 1, 32'd0);
      push_beat(32'h104, 1'b1, 32'h00AABBCC, 4'b0111, 0, 32'd0);
      push_res(last_ld, 1'b0, 4);
      run_access(1'b0, 1'b1, 3'b010, 32'h103, 32'hAABBCCDD, 0, 32'd0);
`else
      push_res(last_ld, 1'b1, 1);
      run_access(1'b1, 1'b0, 3'b010, 32'h101, 32'd0, 0, 32'd0);
      push_res(last_ld, 1'b1, 1);
      run_access(1'b0, 1'b1, 3'b001, 32'h101, 32'h0000ABCD, 0, 32'd0);
      push_res(last_ld, 1'b1, 1);
      run_access(1'b0, 1'b1, 3'b010, 32'h103, 32'hAABBCCDD, 0, 32'd0);
`endif

      // start with neither read nor write is ignored
      @(negedge clock);
      start = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
      #1 check("noop_busy", {31'd0, busy}, 32'd0);
      @(negedge clock);
      check("noop_bus_req", {31'd0, bus_if.bus_req}, 32'd0);
      check("noop_done", {31'd0, done}, 32'd0);
      start = 1'b0;

      // read wins over write when both are set
      push_beat(32'h108, 1'b0, 32'd0, 4'b0000, 0, 32'hCAFEF00D);
      push_res(32'hCAFEF00D, 1'b0, 2);
      run_access(1'b1, 1'b1, 3'b010, 32'h108, 32'h11111111, 0, 32'd0);

      // reset while waiting in ACCESS0
      @(negedge clock);
      start = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
      mem_op_length = 3'b010; address = 32'h200; bus_if.bus_ready = 1'b0;
      @(negedge clock);
      start = 1'b0; mem_read = 1'b0;
      check("abort_req_before", {31'd0, bus_if.bus_req}, 32'd1);
      @(negedge clock);
      #2 reset_n = 1'b0;
      #1 check("abort_req", {31'd0, bus_if.bus_req}, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_load_data", load_data, 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      last_ld = 32'd0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check("abort_no_done", {30'd0, done, bus_if.bus_req}, 32'd0);
      end

      push_beat(32'h104, 1'b0, 32'd0, 4'b0000, 0, 32'h01020304);
      push_res(32'h01020304, 1'b0, 2);
      run_access(1'b1, 1'b0, 3'b010, 32'h104, 32'd0, 0, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-memory access stage between the ALU and the register write-back path of the RV32I core. Takes the ALU result as the effective address plus `rs2_data` and the decoder's `mem_read`/`mem_write`/`mem_op_length` controls, and runs a request/ready transaction on the data bus. It aligns and strobes stores, extracts and sign/zero-extends loads, and stalls the core through `busy` until the access completes.

## Interface
Parameters
- `ADDR_WIDTH`, 32: width of the effective address and `bus_addr`.

Ports
- `clock`  in  1  rising-edge clock; the only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  access request; sampled only in IDLE.
- `mem_read`  in  1  load request from the decoder.
- `mem_write`  in  1  store request from the decoder.
- `mem_op_length`  in  3  funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `address`  in  ADDR_WIDTH  effective byte address (ALU result).
- `store_data`  in  32  store source (`rs2_data`), right-justified.
- `busy`  out  1  stall to the core.
- `done`  out  1  one-cycle completion pulse.
- `load_data`  out  32  extended load result, registered.
- `misaligned`  out  1  access fault flag, valid with `done`.
- `bus_req`  out  1  bus request.
- `bus_we`  out  1  1 for write, 0 for read.
- `bus_addr`  out  ADDR_WIDTH  word-aligned address (bits [1:0] = 0).
- `bus_wdata`  out  32  lane-aligned write data.
- `bus_wstrb`  out  4  byte-lane write enables; 0 on reads.
- `bus_ready`  in  1  slave accepts/completes the current beat.
- `bus_rdata`  in  32  read word; valid when `bus_ready`=1.

## Operation
- States: IDLE, ACCESS0, ACCESS1, DONE.
- IDLE: `start`=1 with `mem_read` or `mem_write` latches address, data, length and direction.
  - `mem_read` has priority if both are set.
  - Neither set: `start` is ignored.
- Lane placement: the store byte goes on lane `address[1:0]`; the store halfword goes on lanes `address[1:0]` and +1.
- Loads: pick the bytes at the offset; B/H sign-extend, BU/HU zero-extend; W passes through.
- Alignment: naturally aligned accesses take one beat (IDLE→ACCESS0→DONE).
- ACCESS0/ACCESS1: hold `bus_req`=1 with all bus outputs stable until `bus_ready`=1 at a rising edge.
- DONE: `done`=1 for one cycle, `load_data` updates (loads only), then IDLE.
- `load_data` holds its value across stores and faults.
- `busy` = (state≠IDLE) | (`start` & (`mem_read`|`mem_write`)) — combinational, so the core stalls in the `start` cycle.

## Timing
- Reset values: state IDLE; `busy`=0 (with `start`=0), `done`=0, `load_data`=0, `misaligned`=0, `bus_req`=0, `bus_we`=0, `bus_addr`=0, `bus_wdata`=0, `bus_wstrb`=0.
- `bus_req` rises the cycle after `start`.
- With zero-wait `bus_ready`, `done` is high 2 cycles after `start`; each wait cycle adds 1.
- `start` during non-IDLE states is ignored.
- Reset mid-access: immediate return to IDLE, `bus_req` drops asynchronously, no `done`; the slave must tolerate an aborted beat.

## Configuration
- `LSU_MISALIGNED_SPLIT_EN` defined:
  - An access that stays within one word proceeds as a single beat at any offset.
  - An access crossing a word boundary (H at offset 3, W at offsets 1–3) takes two beats: ACCESS0 on the lower word, ACCESS1 on word+4.
  - Split loads merge both read words before extension.
  - `misaligned` is always 0.
- Not defined:
  - Any non-naturally-aligned access issues no bus beat.
  - It goes IDLE→DONE with `misaligned`=1 and `done` 1 cycle after `start`.
  - `load_data` is unchanged.

## Structure
- The funct3 length encodings (`MEM_LEN_B/H/W/BU/HU`) and the state encodings go in the shared constants file, alongside the existing MEM_ constants.
- Lane steering and extension form one combinational sub-module, `lsu_align`.
  - Inputs: offset, length, store data, read words.
  - Outputs: wdata, wstrb, load value.
- The FSM and registers stay in `load_store_unit`.

## Test plan
- SW of 0xDEADBEEF to address 0x100, `bus_ready` tied 1:
  - `bus_addr`=0x100, `bus_wstrb`=1111, `bus_wdata`=0xDEADBEEF.
  - `done` 2 cycles after `start`.
- LB from 0x103 with `bus_rdata`=0x80112233 → `load_data`=0xFFFFFF80. LBU from the same address and data → 0x00000080.
- SH of 0x0000ABCD at 0x102 → `bus_wstrb`=1100, `bus_wdata`=0xABCD0000. `bus_ready` delayed 3 cycles → `done` 5 cycles after `start`, bus outputs stable throughout.
- LW at 0x101 without the macro:
  - No `bus_req`.
  - `done`+`misaligned` 1 cycle after `start`, `load_data` unchanged.
- LW at 0x101 with the macro, where word 0x100=0x44332211 and word 0x104=0x88776655:
  - Two beats, at 0x100 then 0x104.
  - `load_data`=0x55443322, `done` 3 cycles after `start`.
- `reset_n` low while waiting in ACCESS0 → `bus_req` 0 immediately, no `done`; the next `start` runs normally.
